// File: rtl/bus_relay_iso.sv
// bus_relay_iso: NCH-channel, DEPTH-stage registered relay with a drain/clamp/wake isolation handshake.
// Define BUS_RELAY_DROP_CNT_EN to add the saturating drop_cnt output and its counter.
module bus_relay_iso #(
  parameter int           NCH      = 4,
  parameter int           W        = 8,
  parameter int           DEPTH    = 2,
  parameter logic [W-1:0] ISO_VAL  = '0,
  parameter int           WAKE_CYC = 2
) (
  input  logic             ck,
  input  logic             srst_n,
  input  logic             isolate,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   out_valid,
  output logic [NCH*W-1:0] out_data,
  output logic             iso_ack
`ifdef BUS_RELAY_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ISO, ST_WAKE} state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DEPTH - 1);
  localparam logic [2:0] WAKE_LOAD  = 3'(WAKE_CYC - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_cnt;
  logic [2:0]       w_next_cnt;
  logic             r_iso_ack;
  logic             w_acc;
  logic [NCH-1:0]   r_valid [DEPTH];
  logic [NCH*W-1:0] r_data  [DEPTH];

  assign w_acc = (r_state == ST_RUN) && !isolate;

  // NOTE: next-state and next-count get defaults first, so no path can leave them unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (isolate) begin
          w_next_state = ST_DRAIN;
          w_next_cnt   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // A drain always runs to completion; isolate is not looked at here.
        if (r_cnt == 3'd0) w_next_state = ST_ISO;
        else               w_next_cnt   = r_cnt - 3'd1;
      end
      ST_ISO: begin
        if (!isolate) begin
          w_next_state = ST_WAKE;
          w_next_cnt   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (isolate)              w_next_state = ST_ISO;
        else if (r_cnt == 3'd0)   w_next_state = ST_RUN;
        else                      w_next_cnt   = r_cnt - 3'd1;
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ck) begin
    if (!srst_n) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_iso_ack <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_iso_ack <= (w_next_state == ST_ISO) || (w_next_state == ST_WAKE);
    end
  end

  // NOTE: pipeline data is reset too, so out_data reads zero after reset instead of stale lanes.
  always_ff @(posedge ck) begin
    if (!srst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      r_valid[0] <= in_valid & ch_en & {NCH{w_acc}};
      r_data[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  // The clamp follows iso_ack so both switch on the same edge.
  assign iso_ack   = r_iso_ack;
  assign out_valid = r_iso_ack ? '0 : r_valid[DEPTH-1];
  assign out_data  = r_iso_ack ? {NCH{ISO_VAL}} : r_data[DEPTH-1];

`ifdef BUS_RELAY_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = (|(in_valid & ch_en)) && !w_acc;

  always_ff @(posedge ck) begin
    if (!srst_n)                                r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_bus_relay_iso.sv
// Testbench for bus_relay_iso: directed scenarios plus randomized traffic against an edge-indexed model.
// Drop counter checks are compiled in when BUS_RELAY_DROP_CNT_EN is defined.
`timescale 1ns/1ps
module tb_bus_relay_iso;
  localparam int           NCH      = 4;
  localparam int           W        = 8;
  localparam int           DEPTH    = 2;
  localparam int           WAKE_CYC = 2;
  localparam logic [W-1:0] ISO_VAL  = 8'hA5;
  localparam logic [NCH*W-1:0] CLAMP = {NCH{ISO_VAL}};

  logic             ck = 1'b0;
  logic             srst_n = 1'b0;
  logic             isolate = 1'b0;
  logic [NCH-1:0]   ch_en = '0;
  logic [NCH-1:0]   in_valid = '0;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0]   out_valid;
  logic [NCH*W-1:0] out_data;
  logic             iso_ack;
`ifdef BUS_RELAY_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bus_relay_iso #(
    .NCH(NCH), .W(W), .DEPTH(DEPTH), .ISO_VAL(ISO_VAL), .WAKE_CYC(WAKE_CYC)
  ) dut (
    .ck(ck),
    .srst_n(srst_n),
    .isolate(isolate),
    .ch_en(ch_en),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .iso_ack(iso_ack)
`ifdef BUS_RELAY_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 ck = ~ck;

  // Reference model: mode plus absolute edge deadlines; captured beats kept in a queue.
  typedef enum {M_RUN, M_DRAIN, M_ISO, M_WAKE} mode_t;
  mode_t            m_mode = M_RUN;
  longint           edge_no = 0;
  longint           m_iso_at = 0;
  longint           m_run_at = 0;
  logic [NCH-1:0]   m_v[$];
  logic [NCH*W-1:0] m_d[$];
  int unsigned      m_drop = 0;

  task automatic model_clear();
    m_mode = M_RUN;
    m_v = {};
    m_d = {};
    for (int i = 0; i < DEPTH; i++) begin
      m_v.push_back('0);
      m_d.push_back('0);
    end
    m_drop = 0;
  endtask

  task automatic model_edge();
    logic acc;
    edge_no++;
    if (!srst_n) begin
      model_clear();
      return;
    end
    acc = (m_mode == M_RUN) && !isolate;
    if ((|(in_valid & ch_en)) && !acc && (m_drop < 65535)) m_drop++;
    m_v.push_back(acc ? (in_valid & ch_en) : '0);
    m_d.push_back(in_data);
    m_v.delete(0);
    m_d.delete(0);
    case (m_mode)
      M_RUN:   if (isolate) begin m_mode = M_DRAIN; m_iso_at = edge_no + DEPTH; end
      M_DRAIN: if (edge_no == m_iso_at) m_mode = M_ISO;
      M_ISO:   if (!isolate) begin m_mode = M_WAKE; m_run_at = edge_no + WAKE_CYC; end
      M_WAKE:  if (isolate) m_mode = M_ISO;
               else if (edge_no == m_run_at) m_mode = M_RUN;
      default: m_mode = M_RUN;
    endcase
  endtask

  task automatic tick();
    @(posedge ck);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    srst_n = 1'b0; isolate = 1'b0; in_valid = '0;
    tick();
    srst_n = 1'b1;
  endtask

  task automatic test_reset();
    srst_n = 1'b0; isolate = 1'b0; ch_en = '1; in_valid = '1; in_data = 32'hDEADBEEF;
    tick();
    srst_n = 1'b1; in_valid = '0;
    n_checks++; if (out_valid !== 4'h0) begin n_errors++; $display("FAIL reset_out_valid got %h expected 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
    n_checks++; if (iso_ack !== 1'b0) begin n_errors++; $display("FAIL reset_iso_ack got %b expected 0", iso_ack); end
`ifdef BUS_RELAY_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_drop_cnt got %h expected 0", drop_cnt); end
`endif
  endtask

  task automatic test_latency();
    ch_en = '1; in_valid = 4'b0101; in_data = 32'h44332211;
    tick();
    in_valid = '0; in_data = '0;
    n_checks++; if (out_valid !== 4'h0) begin n_errors++; $display("FAIL latency_early got %h expected 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 4'b0101) begin n_errors++; $display("FAIL latency_valid got %h expected 5", out_valid); end
    n_checks++; if (out_data !== 32'h44332211) begin n_errors++; $display("FAIL latency_data got %h expected 44332211", out_data); end
    tick();
    n_checks++; if (out_valid !== 4'h0) begin n_errors++; $display("FAIL latency_single got %h expected 0", out_valid); end
  endtask

  task automatic test_iso_entry();
    ch_en = '1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = '1; in_data = {NCH{8'(i)}};
      tick();
    end
    isolate = 1'b1; in_data = 32'h0F0F0F0F;
    tick();
    in_valid = '0;
    n_checks++; if (out_valid !== 4'hF || out_data !== 32'h04040404) begin
      n_errors++; $display("FAIL entry_last_beat got %h/%h expected f/04040404", out_valid, out_data); end
    tick();
    n_checks++; if (out_valid !== 4'h0 || iso_ack !== 1'b0) begin
      n_errors++; $display("FAIL entry_drained got valid %h ack %b expected 0/0", out_valid, iso_ack); end
    tick();
    n_checks++; if (iso_ack !== 1'b1 || out_valid !== 4'h0 || out_data !== CLAMP) begin
      n_errors++; $display("FAIL entry_clamp got ack %b valid %h data %h expected 1/0/%h", iso_ack, out_valid, out_data, CLAMP); end
  endtask

  task automatic test_wake();
    tick(); tick();
    isolate = 1'b0;
    tick();
    n_checks++; if (iso_ack !== 1'b1 || out_data !== CLAMP) begin
      n_errors++; $display("FAIL wake_clamped got ack %b data %h expected 1/%h", iso_ack, out_data, CLAMP); end
    tick();
    n_checks++; if (iso_ack !== 1'b1) begin n_errors++; $display("FAIL wake_hold got %b expected 1", iso_ack); end
    tick();
    n_checks++; if (iso_ack !== 1'b0 || out_valid !== 4'h0) begin
      n_errors++; $display("FAIL wake_run got ack %b valid %h expected 0/0", iso_ack, out_valid); end
    in_valid = 4'b1001; in_data = 32'hC0FFEE11;
    tick();
    in_valid = '0;
    tick();
    n_checks++; if (out_valid !== 4'b1001 || out_data !== 32'hC0FFEE11) begin
      n_errors++; $display("FAIL wake_traffic got %h/%h expected 9/c0ffee11", out_valid, out_data); end
    isolate = 1'b1;
    tick(); tick(); tick();
    isolate = 1'b0;
    tick();
    isolate = 1'b1;
    tick();
    n_checks++; if (iso_ack !== 1'b1 || out_valid !== 4'h0) begin
      n_errors++; $display("FAIL reiso_ack got ack %b valid %h expected 1/0", iso_ack, out_valid); end
    tick(); tick();
    n_checks++; if (iso_ack !== 1'b1) begin n_errors++; $display("FAIL reiso_stay got %b expected 1", iso_ack); end
    isolate = 1'b0;
    tick(); tick();
    n_checks++; if (iso_ack !== 1'b1) begin n_errors++; $display("FAIL rewake_hold got %b expected 1", iso_ack); end
    tick();
    n_checks++; if (iso_ack !== 1'b0) begin n_errors++; $display("FAIL rewake_run got %b expected 0", iso_ack); end
  endtask

`ifdef BUS_RELAY_DROP_CNT_EN
  task automatic test_drop_cnt();
    do_reset();
    ch_en = '1; in_valid = '1; isolate = 1'b1;
    repeat (7) tick();
    in_valid = '0;
    tick();
    n_checks++; if (drop_cnt !== 16'd7) begin n_errors++; $display("FAIL drop_seven got %0d expected 7", drop_cnt); end
    in_valid = 4'b0001;
    repeat (65527) tick();
    n_checks++; if (drop_cnt !== 16'hFFFE) begin n_errors++; $display("FAIL drop_near_sat got %h expected fffe", drop_cnt); end
    repeat (5) tick();
    n_checks++; if (drop_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL drop_sat got %h expected ffff", drop_cnt); end
    do_reset();
    n_checks++; if (drop_cnt !== 16'h0) begin n_errors++; $display("FAIL drop_reset got %h expected 0", drop_cnt); end
  endtask
`endif

  task automatic test_reset_mid_drain();
    do_reset();
    ch_en = '1; in_valid = '1;
    in_data = 32'h10101010; tick();
    in_data = 32'h20202020; tick();
    isolate = 1'b1; in_data = 32'h77777777;
    tick();
    srst_n = 1'b0;
    tick();
    n_checks++; if (out_valid !== 4'h0 || out_data !== 32'h0 || iso_ack !== 1'b0) begin
      n_errors++; $display("FAIL mid_drain_reset got %h/%h/%b expected 0/0/0", out_valid, out_data, iso_ack); end
    srst_n = 1'b1; isolate = 1'b0; in_valid = '0;
    tick();
    n_checks++; if (out_valid !== 4'h0 || iso_ack !== 1'b0) begin
      n_errors++; $display("FAIL mid_drain_flushed got %h/%b expected 0/0", out_valid, iso_ack); end
    in_valid = 4'b0010; in_data = 32'h0000AB00;
    tick();
    in_valid = '0;
    tick();
    n_checks++; if (out_valid !== 4'b0010 || out_data !== 32'h0000AB00) begin
      n_errors++; $display("FAIL mid_drain_run got %h/%h expected 2/0000ab00", out_valid, out_data); end
  endtask

  task automatic test_ch_en();
    int unsigned base;
    base = m_drop;
    ch_en = 4'b1110; in_valid = '1; in_data = 32'h5A5A5A5A;
    tick(); tick();
    n_checks++; if (out_valid !== 4'b1110) begin n_errors++; $display("FAIL ch_en_mask got %h expected e", out_valid); end
`ifdef BUS_RELAY_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 16'(base)) begin n_errors++; $display("FAIL ch_en_no_drop got %0d expected %0d", drop_cnt, base); end
`endif
    ch_en = 4'b0001;
    tick(); tick();
    n_checks++; if (out_valid !== 4'b0001) begin n_errors++; $display("FAIL ch_en_change got %h expected 1", out_valid); end
    in_valid = '0; ch_en = '1;
    tick();
  endtask

  task automatic test_random();
    logic             clamp;
    logic [NCH-1:0]   exp_v;
    logic [NCH*W-1:0] exp_d;
    for (int n = 0; n < 3000; n++) begin
      srst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) isolate = ~isolate;
      ch_en    = NCH'($urandom());
      in_valid = NCH'($urandom());
      in_data  = (NCH*W)'($urandom());
      tick();
      clamp = (m_mode == M_ISO) || (m_mode == M_WAKE);
      exp_v = clamp ? '0 : m_v[0];
      exp_d = clamp ? CLAMP : m_d[0];
      n_checks++; if (out_valid !== exp_v) begin n_errors++; $display("FAIL rand_valid cyc %0d got %h expected %h", n, out_valid, exp_v); end
      n_checks++; if (out_data !== exp_d) begin n_errors++; $display("FAIL rand_data cyc %0d got %h expected %h", n, out_data, exp_d); end
      n_checks++; if (iso_ack !== clamp) begin n_errors++; $display("FAIL rand_ack cyc %0d got %b expected %b", n, iso_ack, clamp); end
`ifdef BUS_RELAY_DROP_CNT_EN
      n_checks++; if (drop_cnt !== 16'(m_drop)) begin n_errors++; $display("FAIL rand_drop cyc %0d got %0d expected %0d", n, drop_cnt, m_drop); end
`endif
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_latency();
    test_iso_entry();
    test_wake();
`ifdef BUS_RELAY_DROP_CNT_EN
    test_drop_cnt();
`endif
    test_reset_mid_drain();
    test_ch_en();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
